// File: rtl/audio_frame_serializer_if.sv
// Frame-in / sample-out bundle for audio_frame_serializer.
// The master side supplies frames and consumes samples; the slave side is the serializer.
interface audio_frame_serializer_if #(
    parameter int INW     = 512,
    parameter int SAMPLEW = 32,
    parameter int DEPTH   = 4
);
    logic                         audio_valid;
    logic [INW-1:0]               audio_in;
    logic                         flush;
    logic                         frame_ready;
    logic                         sample_valid;
    logic [SAMPLEW-1:0]           sample_out;
    logic                         sample_ready;
    logic                         frame_start;
    logic                         frame_last;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;
    logic                         overflow;
    logic [15:0]                  drop_count;

    modport master (
        output audio_valid, audio_in, flush, sample_ready,
        input  frame_ready, sample_valid, sample_out, frame_start, frame_last,
               occupancy, overflow, drop_count
    );

    modport slave (
        input  audio_valid, audio_in, flush, sample_ready,
        output frame_ready, sample_valid, sample_out, frame_start, frame_last,
               occupancy, overflow, drop_count
    );
endinterface

// File: rtl/audio_frame_serializer.sv
// Buffers wide audio frames in a small FIFO and drains them as a first-word-fall-through
// sample stream. Define AFS_DROP_CNT_EN to enable the saturating dropped-frame counter.
module audio_frame_serializer #(
    parameter int INW     = 512,
    parameter int SAMPLEW = 32,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    audio_frame_serializer_if.slave  bus
);
    localparam int NS = INW / SAMPLEW;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    logic [INW-1:0]     mem [DEPTH];
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [OW-1:0]      occ_reg;
    logic [IW-1:0]      idx_reg;
    logic               overflow_reg;
    logic [15:0]        drop_count_reg;

    logic               full;
    logic               valid;
    logic               push;
    logic               drop;
    logic               xfer;
    logic               last_idx;
    logic               pop;
    logic [INW-1:0]     head;
    logic [SAMPLEW-1:0] samples [NS];

    assign full     = (occ_reg == OW'(DEPTH));
    assign valid    = (occ_reg != '0);
    assign push     = bus.audio_valid && !full;
    // A full FIFO drops the incoming frame even when the head pops on the same edge.
    assign drop     = bus.audio_valid && full;
    assign xfer     = valid && bus.sample_ready;
    assign last_idx = (idx_reg == IW'(NS - 1));
    assign pop      = xfer && last_idx;

    assign head = mem[rd_ptr_reg];

    for (genvar gi = 0; gi < NS; gi++) begin : g_slice
        assign samples[gi] = head[gi*SAMPLEW +: SAMPLEW];
    end

    // Flush leaves the RAM untouched, so a concurrent push must not write it either.
    always_ff @(posedge clk) begin
        if (push && !bus.flush)
            mem[wr_ptr_reg] <= bus.audio_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (xfer) begin
                if (last_idx) begin
                    idx_reg    <= '0;
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end else begin
                    idx_reg <= idx_reg + IW'(1);
                end
            end
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + OW'(1);
                2'b01:   occ_reg <= occ_reg - OW'(1);
                default: occ_reg <= occ_reg;
            endcase
            if (drop)
                overflow_reg <= 1'b1;
        end
    end

`ifdef AFS_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count_reg <= '0;
        else if (bus.flush)
            drop_count_reg <= '0;
        else if (drop && drop_count_reg != 16'hFFFF)
            drop_count_reg <= drop_count_reg + 16'd1;
    end
`else
    assign drop_count_reg = '0;
`endif

    assign bus.frame_ready  = !full;
    assign bus.sample_valid = valid;
    assign bus.sample_out   = valid ? samples[idx_reg] : '0;
    assign bus.frame_start  = valid && (idx_reg == '0);
    assign bus.frame_last   = valid && last_idx;
    assign bus.occupancy    = occ_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.drop_count   = drop_count_reg;
endmodule

// File: tb/tb_audio_frame_serializer.sv
// Scoreboard bench for audio_frame_serializer: expected samples are queued when frames are
// accepted and compared against the stream each cycle on the falling edge.
module tb_audio_frame_serializer;
    localparam int INW     = 512;
    localparam int SAMPLEW = 32;
    localparam int DEPTH   = 4;
    localparam int NS      = INW / SAMPLEW;

    typedef struct packed {
        logic [SAMPLEW-1:0] data;
        logic               start;
        logic               last;
    } exp_t;

    logic clk;
    logic rst_n;
    audio_frame_serializer_if #(.INW(INW), .SAMPLEW(SAMPLEW), .DEPTH(DEPTH)) bus ();

    audio_frame_serializer #(.INW(INW), .SAMPLEW(SAMPLEW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    exp_t        exp_q [$];
    int          m_occ = 0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_drops = '0;
    bit          rand_ready = 1'b0;

    logic               prev_stall = 1'b0;
    logic [SAMPLEW-1:0] prev_data;
    logic               prev_start;
    logic               prev_last;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [INW-1:0] make_frame(input logic [31:0] base);
        logic [INW-1:0] f;
        for (int i = 0; i < NS; i++)
            f[i*SAMPLEW +: SAMPLEW] = base + 32'(i);
        return f;
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        m_occ      = 0;
        m_ovf      = 1'b0;
        m_drops    = '0;
        prev_stall = 1'b0;
    endfunction

    // Per-cycle scoreboard: compare against the model state, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            check("occupancy", 32'(bus.occupancy), 32'(m_occ));
            check("frame_ready", 32'(bus.frame_ready), 32'(m_occ < DEPTH));
            check("sample_valid", 32'(bus.sample_valid), 32'(m_occ != 0));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            check("drop_count", 32'(bus.drop_count), 32'(m_drops));
            if (m_occ != 0 && exp_q.size() > 0) begin
                check("sample_out", bus.sample_out, exp_q[0].data);
                check("frame_start", 32'(bus.frame_start), 32'(exp_q[0].start));
                check("frame_last", 32'(bus.frame_last), 32'(exp_q[0].last));
            end
            if (prev_stall) begin
                check("stall_data", bus.sample_out, prev_data);
                check("stall_start", 32'(bus.frame_start), 32'(prev_start));
                check("stall_last", 32'(bus.frame_last), 32'(prev_last));
            end
            if (bus.flush) begin
                model_clear();
            end else begin
                int   inc;
                int   dec;
                exp_t e;
                inc = 0;
                dec = 0;
                prev_stall = (m_occ != 0) && !bus.sample_ready;
                prev_data  = bus.sample_out;
                prev_start = bus.frame_start;
                prev_last  = bus.frame_last;
                if (m_occ != 0 && bus.sample_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (e.last) dec = 1;
                end
                if (bus.audio_valid) begin
                    if (m_occ < DEPTH) begin
                        for (int i = 0; i < NS; i++) begin
                            e.data  = bus.audio_in[i*SAMPLEW +: SAMPLEW];
                            e.start = (i == 0);
                            e.last  = (i == NS - 1);
                            exp_q.push_back(e);
                        end
                        inc = 1;
                    end else begin
                        m_ovf = 1'b1;
`ifdef AFS_DROP_CNT_EN
                        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
`endif
                    end
                end
                m_occ = m_occ + inc - dec;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.sample_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_frame(input logic [31:0] base);
        bus.audio_valid = 1'b1;
        bus.audio_in    = make_frame(base);
        tick();
        bus.audio_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_occ != 0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_frame_ready"}, 32'(bus.frame_ready), 32'd1);
        check({tag, "_sample_valid"}, 32'(bus.sample_valid), 32'd0);
        check({tag, "_sample_out"}, bus.sample_out, 32'd0);
        check({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
        check({tag, "_frame_last"}, 32'(bus.frame_last), 32'd0);
        check({tag, "_occupancy"}, 32'(bus.occupancy), 32'd0);
        check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
        check({tag, "_drop_count"}, 32'(bus.drop_count), 32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.audio_valid  = 1'b0;
        bus.audio_in     = '0;
        bus.flush        = 1'b0;
        bus.sample_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Single frame, consumer always ready.
        bus.sample_ready = 1'b1;
        push_frame(32'h0);
        check("first_latency_valid", 32'(bus.sample_valid), 32'd1);
        check("first_sample", bus.sample_out, 32'h0);
        wait_idle(40);
        $display("single frame drained");

        // Fill, then drop a fifth frame.
        bus.sample_ready = 1'b0;
        for (int f = 1; f <= 5; f++) push_frame(32'(f) << 8);
        check("full_frame_ready", 32'(bus.frame_ready), 32'd0);
        check("full_occupancy", 32'(bus.occupancy), 32'd4);
        bus.sample_ready = 1'b1;
        wait_idle(100);
        $display("fill/overflow drained");

        // Push lands on the edge where sample 15 of the head transfers.
        bus.sample_ready = 1'b0;
        for (int f = 1; f <= 4; f++) push_frame(32'h1000 + (32'(f) << 8));
        bus.sample_ready = 1'b1;
        repeat (NS - 1) tick();
        push_frame(32'hDEAD0000);
        check("pop_drop_occupancy", 32'(bus.occupancy), 32'd3);
        wait_idle(100);
        $display("pop-with-drop drained");

        // Random backpressure across a pointer wrap.
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int n;
            n = 0;
            while (!bus.frame_ready && n < 200) begin
                tick();
                n++;
            end
            check("push_wait_timeout", 32'(n >= 200), 32'd0);
            push_frame(32'h2000 + (32'(f) << 8));
        end
        wait_idle(600);
        rand_ready = 1'b0;
        $display("random backpressure drained");

        // Flush mid-frame with a concurrent push.
        bus.sample_ready = 1'b0;
        push_frame(32'h3000);
        push_frame(32'h3100);
        bus.sample_ready = 1'b1;
        repeat (7) tick();
        check("pre_flush_sample", bus.sample_out, 32'h3007);
        bus.flush = 1'b1;
        push_frame(32'h3200);
        bus.flush = 1'b0;
        check("flush_occupancy", 32'(bus.occupancy), 32'd0);
        check("flush_sample_valid", 32'(bus.sample_valid), 32'd0);
        check("flush_overflow", 32'(bus.overflow), 32'd0);
        repeat (3) tick();
        check("flush_push_not_stored", 32'(bus.sample_valid), 32'd0);
        $display("flush checked");

        // Asynchronous reset mid-drain.
        bus.sample_ready = 1'b0;
        push_frame(32'h4000);
        push_frame(32'h4100);
        bus.sample_ready = 1'b1;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        push_frame(32'h5000);
        check("post_reset_start", 32'(bus.frame_start), 32'd1);
        check("post_reset_sample", bus.sample_out, 32'h5000);
        wait_idle(40);
        $display("async reset checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/audio_frame_serializer.md
# audio_frame_serializer

Downstream of the CPU core's writeback stage. Captures each 512-bit audio frame that the CPU presents with `audio_valid`/`audio_out` into a small frame FIFO. Drains the FIFO as a stream of 32-bit samples over a valid/ready handshake toward the FFT/synth datapath. Decouples the CPU's bursty frame delivery from the sample-rate consumer and flags dropped frames.

## Interface

Parameters:
- `INW`, 512, frame width in bits; must be a multiple of `SAMPLEW`.
- `SAMPLEW`, 32, sample width in bits.
- `DEPTH`, 4, frame FIFO depth; power of two, ≥2.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `audio_valid`  in  1  frame present on `audio_in` this cycle (single-cycle pulse per frame).
- `audio_in`  in  INW  frame data.
- `flush`  in  1  synchronous clear of FIFO, sample index and `overflow`.
- `frame_ready`  out  1  FIFO not full.
- `sample_valid`  out  1  `sample_out` holds a valid sample.
- `sample_out`  out  SAMPLEW  current sample.
- `sample_ready`  in  1  consumer accepts the sample.
- `frame_start`  out  1  current sample is sample 0 of its frame.
- `frame_last`  out  1  current sample is the final sample of its frame.
- `occupancy`  out  $clog2(DEPTH+1)  frames stored, including the partially drained head.
- `overflow`  out  1  sticky; a frame was dropped.
- `drop_count`  out  16  dropped-frame count (see Configuration).

## Operation

- `NS = INW/SAMPLEW` samples per frame (16 by default). Sample index `idx` counts 0..NS-1.
- Push: `audio_valid && !full` writes `audio_in` at the write pointer and increments the write pointer and occupancy.
- Push when full: the frame is discarded and `overflow` is set. This applies even if a pop completes in the same cycle; there is no same-cycle pass-through.
- Sample ordering: `sample_out = head[idx*SAMPLEW +: SAMPLEW]`, least-significant sample first.
- `sample_valid = (occupancy != 0)`. `frame_start = sample_valid && idx==0`. `frame_last = sample_valid && idx==NS-1`.
- Transfer occurs when `sample_valid && sample_ready`. On a transfer:
  - If `idx < NS-1`, `idx` increments.
  - If `idx == NS-1`, `idx` returns to 0, the head frame pops and the read pointer advances.
- `sample_ready` with `sample_valid` low has no effect.
- Simultaneous push and pop (not full): occupancy is unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`. Full/empty is decided from `occupancy`, not from pointer equality.
- `flush` takes priority over push and pop in the same cycle. It zeroes the pointers, `idx`, `occupancy`, `overflow` and `drop_count`. FIFO RAM contents are left unchanged.
- `sample_out` and `frame_start`/`frame_last` must remain stable while `sample_valid && !sample_ready`.

## Timing

- Reset values: `frame_ready`=1, `sample_valid`=0, `sample_out`=0, `frame_start`=0, `frame_last`=0, `occupancy`=0, `overflow`=0, `drop_count`=0. Pointers and `idx` are 0.
- Reset asserted mid-frame discards all stored frames and the partial drain. After reset there is no residual `sample_valid`.
- Latency: a frame pushed at edge N gives `sample_valid`=1 with sample 0 in the cycle after edge N. The read path is first-word-fall-through (combinational from the head entry).
- `frame_ready` is registered-equivalent: it is a function of `occupancy` only, never of `audio_valid` or `sample_ready`.
- Throughput: one sample per cycle when `sample_ready` is held high, so one frame per NS cycles. There is no bubble between frames.
- `overflow` sets the cycle after the dropped push and clears only on reset or `flush`.

## Configuration

- `AFS_DROP_CNT_EN`:
  - Defined: `drop_count` increments on every dropped frame and saturates at 16'hFFFF. It clears on reset and `flush`.
  - Undefined: the counter logic is removed and `drop_count` is tied to 0. `overflow` behaviour is identical in both cases.

## Test plan

- Reset, then push one frame with samples 0x0..0xF in sample order, `sample_ready`=1:
  - `sample_valid` rises the next cycle.
  - 16 consecutive samples 0x0..0xF appear.
  - `frame_start` is high on 0x0 and `frame_last` is high on 0xF.
  - `occupancy` goes 1 then 0.
- Push 4 frames with `sample_ready`=0, then push a 5th:
  - `frame_ready`=0 and `occupancy`=4.
  - The 5th frame is dropped: `overflow`=1 and `drop_count`=1 (macro defined) or 0 (undefined).
  - Draining returns frames 1..4 in order.
- Full FIFO with `sample_ready`=1 and a push on the cycle sample 15 transfers:
  - The push is dropped.
  - `occupancy` becomes 3.
- Toggle `sample_ready` randomly with `DEPTH`=4 across a pointer wrap (6 frames):
  - All 96 samples arrive in order.
  - Outputs stay stable on every stalled cycle.
- Assert `flush` mid-frame (idx=7) while also pushing:
  - Next cycle `occupancy`=0, `sample_valid`=0 and `overflow`=0.
  - The concurrent push is not stored.
- Drop `rst_n` asynchronously mid-drain:
  - Outputs go to their reset values immediately.
  - A new frame after release starts at sample 0.
